// File: rtl/rvfi_trace_checker_if.sv
// Bus bundle between an RVFI retirement source / trace consumer and the checker.
// master = core + host side, slave = rvfi_trace_checker.
interface rvfi_trace_checker_if #(
  parameter int DEPTH   = 16,
  parameter int ORDER_W = 64
) ();
  logic                       in_valid;
  logic [ORDER_W-1:0]         in_order;
  logic [31:0]                in_insn;
  logic [31:0]                in_pc_rdata;
  logic [31:0]                in_pc_wdata;
  logic [4:0]                 in_rd_addr;
  logic [31:0]                in_rd_wdata;
  logic                       in_trap;
  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_pc;
  logic [31:0]                out_insn;
  logic [4:0]                 out_rd_addr;
  logic [31:0]                out_rd_wdata;
  logic [3:0]                 out_flags;
  logic [4:0]                 err_sticky;
  logic                       err_clr;
  logic [$clog2(DEPTH):0]     count;

  modport master (
    output in_valid, in_order, in_insn, in_pc_rdata, in_pc_wdata,
           in_rd_addr, in_rd_wdata, in_trap, out_ready, err_clr,
    input  out_valid, out_pc, out_insn, out_rd_addr, out_rd_wdata,
           out_flags, err_sticky, count
  );

  modport slave (
    input  in_valid, in_order, in_insn, in_pc_rdata, in_pc_wdata,
           in_rd_addr, in_rd_wdata, in_trap, out_ready, err_clr,
    output out_valid, out_pc, out_insn, out_rd_addr, out_rd_wdata,
           out_flags, err_sticky, count
  );
endinterface

// File: rtl/rvfi_trace_checker.sv
// RVFI retirement consumer: per-packet protocol checks plus a first-word
// fall-through FIFO of checked packets drained over a valid/ready stream.
module rvfi_trace_checker #(
  parameter int DEPTH   = 16,
  parameter int ORDER_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rvfi_trace_checker_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [3:0]  flags;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               seen_q, seen_d;
  logic [ORDER_W-1:0] last_order_q, last_order_d;
  logic [31:0]        last_pc_wdata_q, last_pc_wdata_d;
  logic [4:0]         err_q, err_d;

  logic   out_valid_s, full_s, pop_s, push_s;
  logic   order_err_s, pc_err_s, x0_err_s, mis_err_s, ovf_s;
  entry_t entry_s, head_s;

  // Packet checks and FIFO handshake decode.
  always_comb begin
    out_valid_s = (count_q != {CW{1'b0}});
    full_s      = (count_q == CW'(DEPTH));
    pop_s       = out_valid_s & bus.out_ready;
    push_s      = bus.in_valid & (~full_s | pop_s);
    ovf_s       = bus.in_valid & full_s & ~pop_s;
    order_err_s = bus.in_valid & seen_q & (bus.in_order != (last_order_q + ORDER_W'(1)));
    pc_err_s    = bus.in_valid & seen_q & (bus.in_pc_rdata != last_pc_wdata_q);
    x0_err_s    = bus.in_valid & (bus.in_rd_addr == 5'd0) & (bus.in_rd_wdata != 32'd0);
    mis_err_s   = bus.in_valid & (bus.in_pc_wdata[1:0] != 2'b00);

    entry_s.pc       = bus.in_pc_rdata;
    entry_s.insn     = bus.in_insn;
    entry_s.rd_addr  = bus.in_rd_addr;
    entry_s.rd_wdata = bus.in_rd_wdata;
    entry_s.flags    = {bus.in_trap, mis_err_s, x0_err_s, pc_err_s};
  end

  // Next-state for pointers, occupancy, checker history and sticky errors.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    seen_d          = seen_q;
    last_order_d    = last_order_q;
    last_pc_wdata_d = last_pc_wdata_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // History follows every observed packet, including ones the FIFO drops.
    if (bus.in_valid) begin
      seen_d          = 1'b1;
      last_order_d    = bus.in_order;
      last_pc_wdata_d = bus.in_pc_wdata;
    end else begin
      seen_d          = seen_q;
      last_order_d    = last_order_q;
      last_pc_wdata_d = last_pc_wdata_q;
    end

    // Clear first, then OR in this cycle's errors so a coincident error survives.
    if (bus.err_clr) begin
      err_d = {ovf_s, mis_err_s, x0_err_s, pc_err_s, order_err_s};
    end else begin
      err_d = err_q | {ovf_s, mis_err_s, x0_err_s, pc_err_s, order_err_s};
    end
  end

  // Control and checker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q        <= {PW{1'b0}};
      rd_ptr_q        <= {PW{1'b0}};
      count_q         <= {CW{1'b0}};
      seen_q          <= 1'b0;
      last_order_q    <= {ORDER_W{1'b0}};
      last_pc_wdata_q <= 32'd0;
      err_q           <= 5'd0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      seen_q          <= seen_d;
      last_order_q    <= last_order_d;
      last_pc_wdata_q <= last_pc_wdata_d;
      err_q           <= err_d;
    end
  end

  // FIFO storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // Head is forced to zero while empty so stale entries never leak out.
  always_comb begin
    if (out_valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  assign bus.out_valid    = out_valid_s;
  assign bus.out_pc       = head_s.pc;
  assign bus.out_insn     = head_s.insn;
  assign bus.out_rd_addr  = head_s.rd_addr;
  assign bus.out_rd_wdata = head_s.rd_wdata;
  assign bus.out_flags    = head_s.flags;
  assign bus.err_sticky   = err_q;
  assign bus.count        = count_q;
endmodule
